// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP capture controller: FSM state encoding,
// bytes per pixel and the default frame geometry.
package dvp_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LINE = 2'd1,
      CAPTURE   = 2'd2,
      LINE_DONE = 2'd3
   } dvp_state_e;

   localparam int BYTES_PER_PIX = 2;
   localparam int DEF_H_RES     = 640;
   localparam int DEF_V_RES     = 480;
   localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/dvp_edge_det.sv
// Rise/fall pulse generator for an already-synchronised level signal.
// The pulses are combinational from the live input and its registered copy,
// so they are high in the first clock cycle that sees the new level.
module dvp_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic sig_q;

   // Keep the previous sample; reset to 0 so no falling edge fires after reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      if (rst) sig_q <= 1'b0;
      else     sig_q <= sig_i;
   end

   assign rise_o = sig_i & ~sig_q;
   assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Frame/line sequencer between the synchronised DVP inputs and the line FIFO /
// UDP packetiser. Arms at vsync fall, packs byte pairs into 16-bit pixels,
// raises one req/ack handshake per completed line, and keeps sticky drop and
// length error flags.
// Optional build macro DVP_TEST_PATTERN_EN: pix_data carries
// {line_counter[7:0], pixel_counter[7:0]} instead of camera bytes.
module dvp_capture_ctrl
   import dvp_pkg::*;
#(
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap_en,
   input  logic             dvp_vsync,
   input  logic             dvp_href,
   input  logic             dvp_stb,
   input  logic [7:0]       dvp_data,
   output logic [15:0]      pix_data,
   output logic             pix_we,
   output logic             line_req,
   input  logic             line_ack,
   output logic [CNT_W-1:0] line_num,
   output logic [CNT_W-1:0] frame_num,
   output logic             busy,
   output logic             err_drop,
   output logic             err_len
);

   localparam logic [CNT_W-1:0] H_RES_C = CNT_W'(H_RES);
   localparam logic [CNT_W-1:0] V_RES_C = CNT_W'(V_RES);
   localparam logic [CNT_W-1:0] LINE_BYTES_C = CNT_W'(BYTES_PER_PIX * H_RES);

   dvp_state_e       state_q;
   logic [CNT_W-1:0] line_cnt_q;
   logic [CNT_W-1:0] line_cnt_d;
   logic [CNT_W-1:0] pix_cnt_q;
   logic [CNT_W-1:0] frame_num_q;
   logic [7:0]       byte_q;
   logic             phase_q;
   logic             started_q;
   logic             skip_q;
   logic             abort_q;
   logic             line_req_q;
   logic             err_drop_q;
   logic             err_len_q;
   logic             vs_rise, vs_fall, hr_rise, hr_fall;
   logic             pix_fire;
   logic [15:0]      pix_word;

   dvp_edge_det u_vsync_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (dvp_vsync),
      .rise_o (vs_rise),
      .fall_o (vs_fall)
   );

   dvp_edge_det u_href_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (dvp_href),
      .rise_o (hr_rise),
      .fall_o (hr_fall)
   );

   // A line dropped while a request was pending is accounted for on the ack.
   assign line_cnt_d = line_cnt_q + CNT_W'(1) + CNT_W'(skip_q);

   // Second byte of a pixel inside the visible width; an aborting vsync edge
   // suppresses the write because the partial line is discarded anyway.
   assign pix_fire = (state_q == CAPTURE) && dvp_stb && dvp_href && phase_q &&
                     !vs_rise && (pix_cnt_q < H_RES_C);

`ifdef DVP_TEST_PATTERN_EN
   assign pix_word = {line_cnt_q[7:0], pix_cnt_q[7:0]};
`else
   assign pix_word = {byte_q, dvp_data};
`endif

   // The FIFO write strobe must coincide with the second byte, so it is decoded
   // from registered state plus the live strobe rather than registered again.
   assign pix_we    = pix_fire;
   assign pix_data  = pix_fire ? pix_word : 16'h0000;
   assign line_req  = line_req_q;
   assign line_num  = line_cnt_q;
   assign frame_num = frame_num_q;
   assign busy      = (state_q != IDLE);
   assign err_drop  = err_drop_q;
   assign err_len   = err_len_q;

   // Frame/line sequencer with its counters, handshake and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         line_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         frame_num_q <= '0;
         byte_q      <= '0;
         phase_q     <= 1'b0;
         started_q   <= 1'b0;
         skip_q      <= 1'b0;
         abort_q     <= 1'b0;
         line_req_q  <= 1'b0;
         err_drop_q  <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (vs_fall && cap_en) begin
                  state_q    <= WAIT_LINE;
                  line_cnt_q <= '0;
                  skip_q     <= 1'b0;
                  abort_q    <= 1'b0;
                  err_drop_q <= 1'b0;
                  err_len_q  <= 1'b0;
                  started_q  <= 1'b1;
                  if (started_q) frame_num_q <= frame_num_q + CNT_W'(1);
               end
            end

            WAIT_LINE: begin
               if (vs_rise) begin
                  state_q <= IDLE;
               end else if (hr_rise && (line_cnt_q < V_RES_C)) begin
                  state_q   <= CAPTURE;
                  pix_cnt_q <= '0;
                  phase_q   <= 1'b0;
               end
            end

            CAPTURE: begin
               if (vs_rise) begin
                  err_len_q <= 1'b1;
                  state_q   <= IDLE;
               end else if (hr_fall) begin
                  // Byte count is 2*pixels + phase; any odd count is wrong too.
                  if (({pix_cnt_q[CNT_W-2:0], 1'b0} != LINE_BYTES_C) || phase_q ||
                      pix_cnt_q[CNT_W-1])
                     err_len_q <= 1'b1;
                  line_req_q <= 1'b1;
                  state_q    <= LINE_DONE;
               end else if (dvp_stb && dvp_href) begin
                  if (!phase_q) begin
                     byte_q  <= dvp_data;
                     phase_q <= 1'b1;
                  end else begin
                     phase_q <= 1'b0;
                     if (pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                  end
               end
            end

            LINE_DONE: begin
               if (vs_rise) abort_q <= 1'b1;
               if (line_ack) begin
                  line_req_q <= 1'b0;
                  line_cnt_q <= line_cnt_d;
                  skip_q     <= 1'b0;
                  abort_q    <= 1'b0;
                  if (abort_q || vs_rise || (line_cnt_d >= V_RES_C)) begin
                     state_q <= IDLE;
                  end else if (hr_rise) begin
                     state_q   <= CAPTURE;
                     pix_cnt_q <= '0;
                     phase_q   <= 1'b0;
                  end else begin
                     state_q <= WAIT_LINE;
                  end
               end else if (hr_rise) begin
                  err_drop_q <= 1'b1;
                  skip_q     <= 1'b1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Self-checking bench for dvp_capture_ctrl (H_RES=4, V_RES=3). Expected pixels
// and line requests are queued as stimulus is driven and popped by a monitor
// when the DUT produces them.
module tb_dvp_capture_ctrl;

   localparam int H_RES = 4;
   localparam int V_RES = 3;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [CNT_W-1:0] line;
      logic [CNT_W-1:0] frame;
   } req_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             cap_en;
   logic             dvp_vsync;
   logic             dvp_href;
   logic             dvp_stb;
   logic [7:0]       dvp_data;
   logic [15:0]      pix_data;
   logic             pix_we;
   logic             line_req;
   logic             line_ack;
   logic [CNT_W-1:0] line_num;
   logic [CNT_W-1:0] frame_num;
   logic             busy;
   logic             err_drop;
   logic             err_len;

   int          total = 0;
   int          bad   = 0;
   int          pix_seen = 0;
   bit          auto_ack = 1'b0;
   bit          req_prev = 1'b0;
   logic [15:0] pix_q[$];
   req_t        req_q[$];

   dvp_capture_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cap_en    (cap_en),
      .dvp_vsync (dvp_vsync),
      .dvp_href  (dvp_href),
      .dvp_stb   (dvp_stb),
      .dvp_data  (dvp_data),
      .pix_data  (pix_data),
      .pix_we    (pix_we),
      .line_req  (line_req),
      .line_ack  (line_ack),
      .line_num  (line_num),
      .frame_num (frame_num),
      .busy      (busy),
      .err_drop  (err_drop),
      .err_len   (err_len)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] byte_val(input int f, input int l, input int k);
      return 8'(8'h12 + 8'h22 * k + 8'h40 * l + 8'h07 * f);
   endfunction

   // Drive one href window of nbytes strobes. Pixels are expected only when the
   // line is captured; a request is expected only when finish_line and want_req.
   task automatic send_line(input int nbytes, input int frame, input int line,
                            input bit want_pix, input bit finish_line, input bit want_req);
      logic [7:0] b0;
      logic [7:0] b1;
      req_t       r;
      b0 = 8'h00;
      dvp_href = 1'b1;
      tick(2);
      for (int k = 0; k < nbytes; k++) begin
         b1 = byte_val(frame, line, k);
         if ((k % 2) == 0) b0 = b1;
         else if (want_pix && (k / 2) < H_RES) begin
`ifdef DVP_TEST_PATTERN_EN
            pix_q.push_back({8'(line), 8'(k / 2)});
`else
            pix_q.push_back({b0, b1});
`endif
         end
         dvp_data = b1;
         dvp_stb  = 1'b1;
         tick();
         dvp_stb  = 1'b0;
         tick();
      end
      if (finish_line) begin
         if (want_req) begin
            r.line  = CNT_W'(line);
            r.frame = CNT_W'(frame);
            req_q.push_back(r);
         end
         dvp_href = 1'b0;
         tick(2);
      end
   endtask

   task automatic wait_req(input logic level, input string tag);
      int n;
      n = 0;
      while (line_req !== level && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check(tag, 32'(line_req), 32'(level));
   endtask

   task automatic frame_start();
      dvp_vsync = 1'b1;
      tick(3);
      dvp_vsync = 1'b0;
      tick(3);
   endtask

   // Acknowledge a pending request three cycles after it is seen.
   always begin
      @(posedge clk);
      #1;
      if (line_req && auto_ack) begin
         tick(3);
         line_ack = 1'b1;
         tick();
         line_ack = 1'b0;
      end
   end

   // Scoreboard: compare every write and every new request with the queues.
   always @(negedge clk) begin
      if (rst) begin
         req_prev = 1'b0;
      end else begin
         if (pix_we) begin
            pix_seen++;
            if (pix_q.size() == 0) check("pix_unexpected", 32'(pix_q.size()), 32'd1);
            else check("pix_data", 32'(pix_data), 32'(pix_q.pop_front()));
         end
         if (line_req && !req_prev) begin
            if (req_q.size() == 0) check("req_unexpected", 32'(req_q.size()), 32'd1);
            else begin
               req_t r;
               r = req_q.pop_front();
               check("line_num", 32'(line_num), 32'(r.line));
               check("frame_num", 32'(frame_num), 32'(r.frame));
            end
         end
         req_prev = line_req;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cap_en = 1'b0; dvp_vsync = 1'b0; dvp_href = 1'b0;
      dvp_stb = 1'b0; dvp_data = 8'h00; line_ack = 1'b0;
      tick(3);
      check("rst_pix_we", 32'(pix_we), 0);
      check("rst_pix_data", 32'(pix_data), 0);
      check("rst_line_req", 32'(line_req), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'({err_drop, err_len}), 0);
      check("rst_frame", 32'(frame_num), 0);
      rst = 1'b0;
      cap_en = 1'b1;
      auto_ack = 1'b1;

      // Frame 0: three clean lines; the first pixel is 0x12,0x34.
      tick(2);
      pix_seen = 0;
      frame_start();
      check("f0_busy", 32'(busy), 1);
      for (int l = 0; l < V_RES; l++) begin
         send_line(2 * H_RES, 0, l, 1'b1, 1'b1, 1'b1);
         wait_req(1'b0, "f0_ack_timeout");
      end
      check("f0_pix_count", 32'(pix_seen), 32'(H_RES * V_RES));
      check("f0_idle", 32'(busy), 0);
      check("f0_err", 32'({err_drop, err_len}), 0);

      // Frame 1: short line of 7 bytes still requests and sets err_len.
      frame_start();
      send_line(7, 1, 0, 1'b1, 1'b1, 1'b1);
      check("f1_err_len", 32'(err_len), 1);
      wait_req(1'b0, "f1_ack_timeout");
      for (int l = 1; l < V_RES; l++) begin
         send_line(2 * H_RES, 1, l, 1'b1, 1'b1, 1'b1);
         wait_req(1'b0, "f1_ack_timeout");
      end
      check("f1_err_len_sticky", 32'(err_len), 1);
      check("f1_idle", 32'(busy), 0);

      // Frame 2: ack withheld across the next line, which is dropped.
      frame_start();
      check("f2_err_cleared", 32'({err_drop, err_len}), 0);
      auto_ack = 1'b0;
      send_line(2 * H_RES, 2, 0, 1'b1, 1'b1, 1'b1);
      check("f2_req_pending", 32'(line_req), 1);
      send_line(2 * H_RES, 2, 1, 1'b0, 1'b1, 1'b0);
      check("f2_err_drop", 32'(err_drop), 1);
      check("f2_req_held", 32'(line_req), 1);
      auto_ack = 1'b1;
      wait_req(1'b0, "f2_ack_timeout");
      send_line(2 * H_RES, 2, 2, 1'b1, 1'b1, 1'b1);
      wait_req(1'b0, "f2_ack_timeout");
      check("f2_idle", 32'(busy), 0);
      check("f2_err_len", 32'(err_len), 0);

      // Frame 3: vsync rises mid-line; partial line gives no request.
      frame_start();
      send_line(4, 3, 0, 1'b1, 1'b0, 1'b0);
      dvp_vsync = 1'b1;
      tick(2);
      check("f3_abort_idle", 32'(busy), 0);
      check("f3_abort_err_len", 32'(err_len), 1);
      check("f3_no_req", 32'(line_req), 0);
      dvp_href = 1'b0;
      tick(3);

      // Frame 4: reset while a request is pending.
      frame_start();
      auto_ack = 1'b0;
      send_line(7, 4, 0, 1'b1, 1'b1, 1'b1);
      check("f4_req_pending", 32'(line_req), 1);
      check("f4_err_len", 32'(err_len), 1);
      rst = 1'b1;
      tick();
      check("rst2_line_req", 32'(line_req), 0);
      check("rst2_err", 32'({err_drop, err_len}), 0);
      check("rst2_busy", 32'(busy), 0);
      check("rst2_frame", 32'(frame_num), 0);
      rst = 1'b0;
      auto_ack = 1'b1;
      tick(2);

      // After reset the next frame restarts at line 0 of frame 0.
      frame_start();
      for (int l = 0; l < V_RES; l++) begin
         send_line(2 * H_RES, 0, l, 1'b1, 1'b1, 1'b1);
         wait_req(1'b0, "f5_ack_timeout");
      end
      check("f5_idle", 32'(busy), 0);
      tick(4);
      check("pix_queue_empty", 32'(pix_q.size()), 0);
      check("req_queue_empty", 32'(req_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dvp_capture_ctrl.md
Name: dvp_capture_ctrl

Overview:
- Frame/line sequencer between the synchronised DVP camera inputs and the line FIFO / UDP packetiser.
- Uses internal vsync/href edge detection to arm capture at frame start and pack byte pairs into 16-bit pixels.
- Counts pixels and lines, and issues one req/ack transfer request per completed line to the packetiser.
- Also owns drop and error flags.

Parameters:
- H_RES, 640, pixels per line (each pixel is 2 bytes on the bus).
- V_RES, 480, lines per frame.
- CNT_W, 16, width of line and frame counters.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- cap_en  in  1  capture enable, sampled at frame start only.
- dvp_vsync  in  1  vsync, already synchronised to clk; high = vertical blank.
- dvp_href  in  1  href, already synchronised; high = active line.
- dvp_stb  in  1  one-cycle strobe: dvp_data is valid this cycle (pclk edge).
- dvp_data  in  8  camera byte.
- pix_data  out  16  packed pixel; first byte goes to [15:8].
- pix_we  out  1  one-cycle write strobe to the line FIFO.
- line_req  out  1  line ready for packetiser.
- line_ack  in  1  packetiser has accepted the line.
- line_num  out  CNT_W  index of the requested line; stable while line_req is high.
- frame_num  out  CNT_W  frame index; stable while line_req is high.
- busy  out  1  high whenever state is not IDLE.
- err_drop  out  1  sticky: a line was dropped because the request was still pending.
- err_len  out  1  sticky: line byte count was not 2*H_RES.

Behaviour:
- Reset values: all outputs are 0; state = IDLE; counters = 0; byte phase = 0.
- Edge detection:
  - Registered previous values of vsync and href; fall/rise pulses are combinational from the current and registered values.
  - Edge pulses assert 1 cycle after the input transition.
  - After reset the registered values equal 0, so no spurious edge fires on the first cycle.
- IDLE:
  - On vsync falling edge with cap_en = 1: go to WAIT_LINE, clear line counter.
  - frame_num is incremented at every frame start except the first after reset.
- WAIT_LINE:
  - href rise with line counter < V_RES: go to CAPTURE, clear pixel counter and byte phase.
  - href rise with line counter = V_RES: ignored.
- CAPTURE, on each dvp_stb with href = 1:
  - Phase 0: latch byte.
  - Phase 1: drive pix_data = {latched, dvp_data} with pix_we = 1 that same cycle, increment pixel counter.
  - Pixels beyond H_RES are not written (no pix_we) but are counted for the length check.
- href fall in CAPTURE:
  - err_len is set if byte count ≠ 2*H_RES or phase = 1.
  - Go to LINE_DONE.
- LINE_DONE:
  - Assert line_req with line_num = current line, hold until the cycle line_ack = 1.
  - On ack: deassert line_req next cycle, increment line counter, return to WAIT_LINE.
  - Line counter reaching V_RES goes to IDLE instead of WAIT_LINE.
- Drop: href rise while in LINE_DONE.
  - Set err_drop, skip that line (no pix_we), keep the pending request.
  - Increment the line counter once for the skipped line after the pending line completes.
- vsync rise in WAIT_LINE/CAPTURE/LINE_DONE (frame aborted):
  - CAPTURE: drop the partial line, set err_len.
  - LINE_DONE: keep the pending request until ack.
  - Then go to IDLE.
- cap_en deasserted mid-frame: the current frame completes; no re-arm.
- Simultaneous line_ack and href rise in LINE_DONE: the ack takes priority, go directly to CAPTURE; no drop.
- rst at any time: immediate return to reset values; sticky errors cleared.
- Errors are sticky; cleared only by rst or by frame start with cap_en = 1.

Optional Feature:
- Macro: DVP_TEST_PATTERN_EN.
- Defined: pix_data is replaced by {line_counter[7:0], pixel_counter[7:0]}; timing, pix_we and all checks are unchanged.
- Undefined: camera data only; no pattern logic is synthesised.

Decomposition:
- Package dvp_pkg: state encoding IDLE/WAIT_LINE/CAPTURE/LINE_DONE; BYTES_PER_PIX = 2; default H_RES/V_RES constants.
- Sub-module dvp_edge_det (sync active-high reset): one instance each for vsync and href, providing rise/fall pulses.

Test Plan:
- Frame with H_RES=4, V_RES=2, 8 strobes per line, ack 3 cycles after req -> 8 pix_we total; line_num 0 then 1; state returns to IDLE; no errors.
- Bytes 0x12, 0x34 -> pix_data = 0x1234 with pix_we for exactly 1 cycle.
- Line of 7 bytes -> err_len = 1; line_req still issued.
- Ack withheld across the next href rise -> err_drop = 1, that line gives no pix_we; line_num of the following req skips by 2.
- vsync rises mid-CAPTURE -> state goes to IDLE, no line_req for the partial line, err_len = 1.
- rst pulsed during LINE_DONE -> line_req = 0 and all flags = 0 on the next cycle; next vsync fall restarts at line 0.
